// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one valid/ready request per load or store,
// aligns and extends load data, and reports misaligned and access-fault exceptions.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  input  logic            rd_en_i,
  input  logic            wr_en_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            dmem_req_valid_o,
  input  logic            dmem_req_ready_i,
  output logic [XLEN-1:0] dmem_req_addr_o,
  output logic            dmem_req_we_o,
  output logic [3:0]      dmem_req_wstrb_o,
  output logic [XLEN-1:0] dmem_req_wdata_o,
  input  logic            dmem_rsp_valid_i,
  input  logic [XLEN-1:0] dmem_rsp_rdata_i,
  input  logic            dmem_rsp_err_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            done_o,
  output logic            stall_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [XLEN-1:0] exc_tval_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic            mem_op, misal_in, accept, rsp_take, timeout;
  logic [3:0]      wstrb_in;
  logic [XLEN-1:0] wdata_in;

  logic [XLEN-1:0] addr_q, wdata_q, load_q, tval_q;
  logic [1:0]      size_q;
  logic            uns_q, we_q, kill_q, orphan_q, done_q, exc_q;
  logic [3:0]      wstrb_q, cause_q;
  logic [31:0]     cnt_q;

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] lo,
                                                   input logic [1:0] size,
                                                   input logic uns);
    logic [XLEN-1:0] sh_b, sh_h;
    sh_b = rdata >> {lo, 3'b000};
    sh_h = rdata >> {lo[1], 4'b0000};
    case (size)
      2'b00:   load_extract = {{(XLEN-8){sh_b[7] & ~uns}}, sh_b[7:0]};
      2'b01:   load_extract = {{(XLEN-16){sh_h[15] & ~uns}}, sh_h[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  always_comb begin
    mem_op   = req_valid_i && (rd_en_i || wr_en_i);
    misal_in = 1'b0;
    wstrb_in = 4'b0000;
    wdata_in = '0;
    case (size_i)
      2'b00:   misal_in = 1'b0;
      2'b01:   misal_in = addr_i[0];
      default: misal_in = (addr_i[1:0] != 2'b00);
    endcase
    // Store wins when both enables are set; loads carry no strobes.
    if (wr_en_i) begin
      case (size_i)
        2'b00: begin
          wstrb_in = 4'b0001 << addr_i[1:0];
          wdata_in = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          wstrb_in = 4'b0011 << {addr_i[1], 1'b0};
          wdata_in = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_in = 4'b1111;
          wdata_in = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_take  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (mem_op && !flush_i) begin
        accept    = 1'b1;
        state_nxt = misal_in ? DONE : REQ;
      end
      REQ: if (dmem_req_ready_i) state_nxt = WAIT;
      WAIT: begin
        // A response owed to a timed-out request is dropped, not captured.
        if (dmem_rsp_valid_i && !orphan_q) begin
          rsp_take  = 1'b1;
          state_nxt = DONE;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      kill_q   <= 1'b0;
      orphan_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
      load_q   <= '0;
    end else begin
      state   <= state_nxt;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      tval_q  <= '0;
      load_q  <= '0;
      if (accept) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        uns_q   <= unsigned_i;
        we_q    <= wr_en_i;
        wstrb_q <= wstrb_in;
        wdata_q <= wdata_in;
        if (misal_in) begin
          done_q  <= 1'b1;
          exc_q   <= 1'b1;
          cause_q <= wr_en_i ? 4'd6 : 4'd4;
          tval_q  <= addr_i;
        end
      end
      if (state == REQ && dmem_req_ready_i) cnt_q <= '0;
      else if (state == WAIT)               cnt_q <= cnt_q + 32'd1;
      if ((state == REQ || state == WAIT) && flush_i) kill_q <= 1'b1;
      else if (state == DONE)                         kill_q <= 1'b0;
      if (timeout)               orphan_q <= 1'b1;
      else if (dmem_rsp_valid_i) orphan_q <= 1'b0;
      if ((rsp_take || timeout) && !(kill_q || flush_i)) begin
        done_q <= 1'b1;
        if (timeout || dmem_rsp_err_i) begin
          exc_q   <= 1'b1;
          cause_q <= we_q ? 4'd7 : 4'd5;
          tval_q  <= addr_q;
        end else if (!we_q) begin
          load_q <= load_extract(dmem_rsp_rdata_i, addr_q[1:0], size_q, uns_q);
        end
      end
    end
  end

  // A flush arriving in the DONE cycle still retracts the completion and exception.
  assign done_o           = done_q && !flush_i;
  assign exc_valid_o      = exc_q && !flush_i;
  assign exc_cause_o      = exc_valid_o ? cause_q : 4'd0;
  assign exc_tval_o       = exc_valid_o ? tval_q : '0;
  assign load_data_o      = load_q;
  assign stall_o          = (state == IDLE && mem_op && !flush_i) || state == REQ || state == WAIT;
  assign dmem_req_valid_o = (state == REQ);
  assign dmem_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_req_we_o    = we_q;
  assign dmem_req_wstrb_o = wstrb_q;
  assign dmem_req_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned loads/stores, back-pressure, misalignment,
// bus errors, watchdog timeout with a late response, flush and mid-transaction reset.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, rd_en, wr_en, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] load_data, exc_tval;
  logic        done, stall, exc_valid;
  logic [3:0]  exc_cause;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .rd_en_i(rd_en), .wr_en_i(wr_en), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata),
    .dmem_req_valid_o(dreq_valid), .dmem_req_ready_i(dreq_ready),
    .dmem_req_addr_o(dreq_addr), .dmem_req_we_o(dreq_we),
    .dmem_req_wstrb_o(dreq_wstrb), .dmem_req_wdata_o(dreq_wdata),
    .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_rdata_i(rsp_rdata), .dmem_rsp_err_i(rsp_err),
    .load_data_o(load_data), .done_o(done), .stall_o(stall),
    .exc_valid_o(exc_valid), .exc_cause_o(exc_cause), .exc_tval_o(exc_tval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input logic r, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; rd_en = r; wr_en = w; size = sz; uns = u; addr = a; wdata = wd;
  endtask

  task automatic clear_op();
    req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Aligned op: IDLE accept, `hold` REQ cycles without ready, accept, response next cycle.
  task automatic run_op(input string tag, input logic r, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input logic [31:0] rdata, input logic err,
                        input logic exp_we, input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                        input logic [31:0] exp_load, input logic exp_exc, input logic [3:0] exp_cause);
    drive_op(r, w, sz, u, a, wd);
    dreq_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
    chk({tag, ".noreq_idle"}, 32'(dreq_valid), 32'd0);
    step(); clear_op();
    for (int i = 0; i <= hold; i++) begin
      dreq_ready = (i == hold);
      @(negedge clk);
      chk({tag, ".req_valid"}, 32'(dreq_valid), 32'd1);
      chk({tag, ".req_addr"}, dreq_addr, {a[31:2], 2'b00});
      chk({tag, ".req_we"}, 32'(dreq_we), 32'(exp_we));
      chk({tag, ".req_wstrb"}, 32'(dreq_wstrb), 32'(exp_strb));
      if (exp_we) chk({tag, ".req_wdata"}, dreq_wdata, exp_wd);
      step();
    end
    dreq_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
    @(negedge clk);
    chk({tag, ".wait_noreq"}, 32'(dreq_valid), 32'd0);
    chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
    chk({tag, ".wait_done"}, 32'(done), 32'd0);
    step(); rsp_valid = 1'b0; rsp_err = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".load_data"}, load_data, exp_load);
    chk({tag, ".exc_valid"}, 32'(exc_valid), 32'(exp_exc));
    chk({tag, ".exc_cause"}, 32'(exc_cause), 32'(exp_cause));
    chk({tag, ".exc_tval"}, exc_tval, exp_exc ? a : 32'd0);
    step();
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    step();
  endtask

  task automatic run_misal(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [3:0] exp_cause);
    drive_op(!w, w, sz, 1'b0, a, 32'h1234_5678);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'd1);
    step(); clear_op();
    @(negedge clk);
    chk({tag, ".noreq"}, 32'(dreq_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".exc_valid"}, 32'(exc_valid), 32'd1);
    chk({tag, ".exc_cause"}, 32'(exc_cause), 32'(exp_cause));
    chk({tag, ".exc_tval"}, exc_tval, a);
    chk({tag, ".load_data"}, load_data, 32'd0);
    step();
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".noreq_after"}, 32'(dreq_valid), 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clear_op(); size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    dreq_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req_valid", 32'(dreq_valid), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.exc_valid", 32'(exc_valid), 32'd0);
    chk("rst.req_wstrb", 32'(dreq_wstrb), 32'd0);
    step(); rst = 1'b0; step();

    run_op("lw",   1, 0, 2'b10, 0, 32'h1000, 0, 0, 32'hDEAD_BEEF, 0, 0, 4'h0, 0, 32'hDEAD_BEEF, 0, 0);
    run_op("lb",   1, 0, 2'b00, 0, 32'h1003, 0, 0, 32'h8012_3456, 0, 0, 4'h0, 0, 32'hFFFF_FF80, 0, 0);
    run_op("lbu",  1, 0, 2'b00, 1, 32'h1003, 0, 0, 32'h8012_3456, 0, 0, 4'h0, 0, 32'h0000_0080, 0, 0);
    run_op("lhu",  1, 0, 2'b01, 1, 32'h1002, 0, 0, 32'h8012_3456, 0, 0, 4'h0, 0, 32'h0000_8012, 0, 0);
    run_op("lh",   1, 0, 2'b01, 0, 32'h1002, 0, 0, 32'h8012_3456, 0, 0, 4'h0, 0, 32'hFFFF_8012, 0, 0);
    run_op("lb0",  1, 0, 2'b00, 0, 32'h1000, 0, 0, 32'h8012_3456, 0, 0, 4'h0, 0, 32'h0000_0056, 0, 0);
    run_op("sh",   0, 1, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 3, 0, 0, 1, 4'hC, 32'hABCD_ABCD, 0, 0, 0);
    run_op("sb",   0, 1, 2'b00, 0, 32'h2001, 32'h0000_00A5, 0, 0, 0, 1, 4'h2, 32'hA5A5_A5A5, 0, 0, 0);
    run_op("sw",   0, 1, 2'b10, 0, 32'h2004, 32'h1122_3344, 1, 0, 0, 1, 4'hF, 32'h1122_3344, 0, 0, 0);
    run_op("both", 1, 1, 2'b10, 0, 32'h2008, 32'hCAFE_F00D, 0, 32'h5555_5555, 0, 1, 4'hF, 32'hCAFE_F00D, 0, 0, 0);
    run_op("lerr", 1, 0, 2'b10, 0, 32'h7000, 0, 0, 32'h1111_1111, 1, 0, 4'h0, 0, 0, 1, 4'd5);
    run_op("serr", 0, 1, 2'b10, 0, 32'h7004, 32'h9, 0, 0, 1, 1, 4'hF, 32'h9, 0, 1, 4'd7);

    run_misal("mis_lw", 0, 2'b10, 32'h3001, 4'd4);
    run_misal("mis_sw", 1, 2'b10, 32'h3002, 4'd6);
    run_misal("mis_lh", 0, 2'b01, 32'h3003, 4'd4);

    // Flush in IDLE: operation is dropped entirely.
    drive_op(1, 0, 2'b10, 0, 32'h4400, 0); flush = 1'b1;
    @(negedge clk);
    chk("flush_idle.stall", 32'(stall), 32'd0);
    step(); clear_op(); flush = 1'b0;
    @(negedge clk);
    chk("flush_idle.noreq", 32'(dreq_valid), 32'd0);
    chk("flush_idle.done", 32'(done), 32'd0);
    step();

    // Watchdog: eight WAIT cycles without a response, then a load fault.
    drive_op(1, 0, 2'b10, 0, 32'h4000, 0); dreq_ready = 1'b1;
    step(); clear_op();
    @(negedge clk);
    chk("to.req_valid", 32'(dreq_valid), 32'd1);
    step(); dreq_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to.wait_done", 32'(done), 32'd0);
      chk("to.wait_stall", 32'(stall), 32'd1);
      step();
    end
    @(negedge clk);
    chk("to.done", 32'(done), 32'd1);
    chk("to.exc_cause", 32'(exc_cause), 32'd5);
    chk("to.exc_tval", exc_tval, 32'h4000);
    step();
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late.stall", 32'(stall), 32'd0);
    step(); rsp_valid = 1'b0;
    @(negedge clk);
    chk("late.done", 32'(done), 32'd0);
    chk("late.load_data", load_data, 32'd0);
    step();
    run_op("after_to", 1, 0, 2'b10, 0, 32'h4004, 0, 0, 32'h0BAD_CAFE, 0, 0, 4'h0, 0, 32'h0BAD_CAFE, 0, 0);

    // Flush while waiting: the response is consumed but no completion is reported.
    drive_op(1, 0, 2'b10, 0, 32'h5000, 0); dreq_ready = 1'b1;
    step(); clear_op();
    step(); dreq_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_wait.stall", 32'(stall), 32'd1);
    step(); flush = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hAAAA_5555;
    @(negedge clk);
    chk("flush_wait.done0", 32'(done), 32'd0);
    step(); rsp_valid = 1'b0;
    @(negedge clk);
    chk("flush_wait.done", 32'(done), 32'd0);
    chk("flush_wait.exc", 32'(exc_valid), 32'd0);
    chk("flush_wait.load", load_data, 32'd0);
    chk("flush_wait.stall_done", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    chk("flush_wait.done_after", 32'(done), 32'd0);
    step();

    // Reset in REQ abandons the request.
    drive_op(1, 0, 2'b10, 0, 32'h6000, 0); dreq_ready = 1'b0;
    step(); clear_op();
    @(negedge clk);
    chk("rst_req.req_valid", 32'(dreq_valid), 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_req.noreq", 32'(dreq_valid), 32'd0);
    chk("rst_req.stall", 32'(stall), 32'd0);
    chk("rst_req.done", 32'(done), 32'd0);
    chk("rst_req.addr", dreq_addr, 32'd0);
    step(); step();
    @(negedge clk);
    chk("rst_req.done_later", 32'(done), 32'd0);
    chk("rst_req.noreq_later", 32'(dreq_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit, directly downstream of the execute stage.
- Consumes the execute-stage effective address (ALU result) and forwarded store data, and drives a valid/ready request channel to the data memory/cache.
- Aligns and extends load data, and raises misaligned and access-fault exceptions.
- Holds the pipeline with stall_o while a transaction is outstanding.

Parameters:
- XLEN, 32: data/address width (only 32 supported).
- TIMEOUT_CYCLES, 0: cycles in WAIT before forced access fault; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  kill current/incoming op (trap, mispredict).
- req_valid_i  in  1  EX/MEM register holds a valid instruction.
- rd_en_i  in  1  load.
- wr_en_i  in  1  store.
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- unsigned_i  in  1  zero-extend load (LBU/LHU).
- addr_i  in  XLEN  effective address from execute.
- wdata_i  in  XLEN  store data (forwarded rs2).
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  request accepted.
- dmem_req_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_req_we_o  out  1  write.
- dmem_req_wstrb_o  out  4  byte enables.
- dmem_req_wdata_o  out  XLEN  lane-replicated store data.
- dmem_rsp_valid_i  in  1  response valid (one per accepted request).
- dmem_rsp_rdata_i  in  XLEN  read word.
- dmem_rsp_err_i  in  1  bus error, qualified by rsp_valid.
- load_data_o  out  XLEN  aligned, extended load result (valid with done_o).
- done_o  out  1  one-cycle completion pulse.
- stall_o  out  1  hold upstream stages.
- exc_valid_o  out  1  exception, valid with done_o.
- exc_cause_o  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault.
- exc_tval_o  out  XLEN  faulting byte address.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE, all registers and outputs 0; reset mid-transaction abandons it with no done_o.
- Memory op = req_valid_i && (rd_en_i || wr_en_i). If both enables are set, the store wins.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, memory op, !flush_i:
  - Latch addr, size, unsigned, we, wstrb and wdata.
  - If misaligned → DONE with exception; no memory request is issued.
  - Otherwise → REQ.
- IDLE, non-memory op or flush_i → stay in IDLE; stall_o=0.
- stall_o = (IDLE && memory op && !flush_i) || REQ || WAIT. It is 0 in DONE.
- REQ:
  - dmem_req_valid_o=1; request fields come from latches and stay stable until accepted.
  - dmem_req_ready_i=1 → WAIT.
  - valid is never withdrawn before ready.
- WAIT:
  - dmem_rsp_valid_i → capture rdata/err → DONE. A response is never expected in the same cycle as acceptance.
  - Watchdog (TIMEOUT_CYCLES>0): counter clears on WAIT entry. Reaching TIMEOUT_CYCLES → DONE with access fault; the late response is then ignored.
- DONE:
  - done_o=1 for exactly one cycle; then → IDLE.
  - Inputs are ignored during DONE (the pipeline advances at the end of this cycle).
  - Minimum latency, aligned op with immediate ready and response next cycle: 4 cycles from req_valid_i to done_o.
  - Misaligned op: done_o 1 cycle after acceptance.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata unchanged.
  - Loads: we=0, wstrb=0000.
- Load extract:
  - byte = rdata>>(8*addr[1:0]); LB/LBU extend bit7.
  - half = rdata>>(16*addr[1]); LH/LHU extend bit15.
  - unsigned_i selects zero-extension.
- load_data_o is 0 for stores and exceptions. exc_tval_o = latched addr when exc_valid_o is set, else 0.
- flush_i:
  - In IDLE: op ignored.
  - In REQ/WAIT: set a kill flag; the bus transaction still completes (handshake rules respected). Kill applies to any issued store as well.
  - In DONE, or on completion of a killed op: done_o=0, exc_valid_o=0.
  - Kill clears on IDLE entry.
- done_o, load_data_o and exc_* are registered outputs.

Test Plan:
- LW addr 0x1000, ready immediate, rsp next cycle rdata 0xDEADBEEF → done_o at cycle 4, load_data_o=0xDEADBEEF, stall_o high cycles 1-3.
- LB addr 0x1003, rdata 0x80123456 → 0xFFFFFF80; LBU → 0x00000080; LHU addr 0x1002 → 0x00008012.
- SH addr 0x2002 wdata 0x0000ABCD → wstrb=1100, wdata=0xABCDABCD, we=1; ready held low 3 cycles → valid and fields stable throughout.
- LW addr 0x3001 → no dmem_req_valid_o, done_o next cycle, exc cause 4, tval 0x3001; SW 0x3002 → cause 6.
- Load with dmem_rsp_err_i=1 → cause 5; TIMEOUT_CYCLES=8 with no response → cause 5 after 8 WAIT cycles; a late response is ignored.
- flush_i asserted in WAIT → response consumed, done_o never pulses; rst_i in REQ → IDLE next cycle, all outputs 0.
